// File: rtl/mtr_drv.sv
// Dual-channel H-bridge PWM driver: signed speed commands become complementary,
// dead-time separated gate pairs, with duty latched once per 2048-clk period.
module mtr_drv #(
    parameter logic [10:0] NONOVERLAP = 11'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lft_pwm1,
    output logic        lft_pwm2,
    output logic        rght_pwm1,
    output logic        rght_pwm2,
    output logic        pwm_synch
);

    localparam logic [10:0] CNT_LAST  = 11'h7FF;
    localparam logic [10:0] DUTY_ZERO = 11'h400;

    logic [10:0] cnt;
    logic [10:0] lft_duty;
    logic [10:0] rght_duty;

    logic lft_pwm1_nxt;
    logic lft_pwm2_nxt;
    logic rght_pwm1_nxt;
    logic rght_pwm2_nxt;

    // Compares are widened to 12 bits so duty + NONOVERLAP cannot wrap near full scale.
    function automatic logic fwd_gate(input logic [10:0] c, input logic [10:0] d);
        return ({1'b0, c} >= {1'b0, NONOVERLAP}) && ({1'b0, c} < {1'b0, d});
    endfunction

    function automatic logic cmp_gate(input logic [10:0] c, input logic [10:0] d);
        return ({1'b0, c} >= ({1'b0, d} + {1'b0, NONOVERLAP})) && (c != CNT_LAST);
    endfunction

    always_comb begin
        lft_pwm1_nxt  = fwd_gate(cnt, lft_duty);
        lft_pwm2_nxt  = cmp_gate(cnt, lft_duty);
        rght_pwm1_nxt = fwd_gate(cnt, rght_duty);
        rght_pwm2_nxt = cmp_gate(cnt, rght_duty);
    end

    // Duty only reloads on the last count so a period never changes shape mid-way;
    // flipping the sign bit maps -1024..+1023 onto 0..2047.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lft_duty  <= DUTY_ZERO;
            rght_duty <= DUTY_ZERO;
            lft_pwm1  <= 1'b0;
            lft_pwm2  <= 1'b0;
            rght_pwm1 <= 1'b0;
            rght_pwm2 <= 1'b0;
            pwm_synch <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            if (cnt == CNT_LAST) begin
                lft_duty  <= {~lft_spd[10], lft_spd[9:0]};
                rght_duty <= {~rght_spd[10], rght_spd[9:0]};
            end
            lft_pwm1  <= lft_pwm1_nxt;
            lft_pwm2  <= lft_pwm2_nxt;
            rght_pwm1 <= rght_pwm1_nxt;
            rght_pwm2 <= rght_pwm2_nxt;
            pwm_synch <= (cnt == 11'd0);
        end
    end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Dual-channel motor PWM driver that sits directly downstream of the PID controller. It converts the signed 11-bit left/right speed commands into complementary, non-overlapping H-bridge gate signals for each motor. Commands are sampled once per PWM period, so the duty cycle can never change mid-period. It also emits a once-per-period sync pulse for downstream samplers such as the ADC/current-sense logic.

## Interface

Parameters:
- NONOVERLAP, default 11'h040 — dead-time in clk cycles between one gate falling and its complement rising.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- lft_spd  input  11  signed left speed command (two's complement, -1024..+1023), from PID
- rght_spd  input  11  signed right speed command, from PID
- lft_pwm1  output  1  left high-side/forward gate
- lft_pwm2  output  1  left complementary gate
- rght_pwm1  output  1  right high-side/forward gate
- rght_pwm2  output  1  right complementary gate
- pwm_synch  output  1  one-clk pulse marking the start of each PWM period

## Operation

- One free-running 11-bit period counter `cnt`, shared by both channels. It counts 0..2047 and wraps 2047→0. Period is 2048 clks.
- Duty conversion, per channel: `duty = spd + 11'h400`, modulo 2^11 (equivalently, invert the MSB).
  - -1024 → 0
  - 0 → 1024
  - +1023 → 2047
- Duty is double-buffered. `lft_duty` and `rght_duty` load from the inputs only on the clk where `cnt == 2047`, and take effect from `cnt == 0`. Input changes at any other count have no effect until the next period.
- Next-state gate logic, per channel. Compares use 12-bit unsigned arithmetic so `duty + NONOVERLAP` cannot wrap.
  - pwm1_nxt = (cnt >= NONOVERLAP) && (cnt < duty)
  - pwm2_nxt = (cnt >= duty + NONOVERLAP) && (cnt != 2047)
- All four gate outputs are flops driven by pwm*_nxt.
- pwm_synch is a flop, set to (cnt == 0).
- Non-overlap guarantees:
  - pwm1 and pwm2 of a channel are never high in the same cycle.
  - At least NONOVERLAP low cycles separate pwm1 falling and pwm2 rising.
  - At least NONOVERLAP+1 low cycles separate pwm2 falling and the next pwm1 rising.
- Boundary behaviour:
  - duty <= NONOVERLAP: pwm1 stays low for the whole period.
  - duty + NONOVERLAP >= 2047: pwm2 stays low for the whole period.
  - duty == 0: pwm2 is high for cnt NONOVERLAP..2046.
  - duty == 2047: pwm1 is high for cnt NONOVERLAP..2046.
- The two channels are fully independent except for the shared counter and sync.

## Timing

- Reset values:
  - cnt = 0
  - lft_duty = rght_duty = 11'h400 (zero speed)
  - all gate outputs = 0
  - pwm_synch = 0
- Latency:
  - Gates: each gate output reflects the comparison on the previous cycle's cnt. pwm1 rises the clk after cnt == NONOVERLAP and falls the clk after cnt == duty.
  - Sync: pwm_synch is high for exactly one clk, the cycle after cnt == 0, i.e. while cnt == 1.
- Command-to-output: a new spd value present on the clk where cnt == 2047 drives gates starting at cnt == 1 of the next period. Worst case is 2049 clks from input change to gate effect.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronously). After release, counting restarts at 0 with 50% duty until the first latch at cnt == 2047.
- No handshake. Inputs are level-sampled, and the upstream stage need not hold them stable except on the latch cycle.

## Test plan

1. Reset then idle, spd = 0 on both channels → per channel:
   - pwm1 high 960 clks per period (cnt 64..1023)
   - pwm2 high 959 clks (cnt 1088..2046)
   - pwm_synch pulses every 2048 clks
2. lft_spd = 11'h3FF, rght_spd = 11'h400 (-1024) →
   - lft_pwm1 high 1983 clks, lft_pwm2 never high
   - rght_pwm1 never high, rght_pwm2 high 1983 clks
3. lft_spd = 11'h040 (+64), so duty = 1088 →
   - lft_pwm1 high 1024 clks (cnt 64..1087)
   - lft_pwm2 high cnt 1152..2046 (895 clks)
4. Change lft_spd from 0 to +256 while cnt == 500 → current period is unchanged (pwm1 falls after cnt 1023). The next period has pwm1 falling after cnt 1279.
5. Pulse rst_n low at cnt == 700 with spd = +512 →
   - all outputs are 0 during reset
   - after release, first period is 50% duty (pwm1 high cnt 64..1023)
   - the following period reflects duty 1536
6. Random spd sweep over 200 periods → checker asserts:
   - pwm1 & pwm2 is never 1 on either channel
   - both the pwm1-fall→pwm2-rise and pwm2-fall→pwm1-rise gaps are at least 64 clks
   - per-period high counts match the formula in Operation
